cmd_uart_rx: RTL and testbench

Upstream feeder of the command processor. Receives 8N1 serial bytes on RX from the BLE module and pairs them, high byte first, into a 16-bit command word. Presents the word as cmd with a cmd_rdy flag that the command processor clears via clr_cmd_rdy. Contains its own RX synchronizer, a bit-level receiver FSM and a byte-pair assembler FSM with an inter-byte timeout.

---
 rtl/cmd_uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_cmd_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_rx.sv
// Purpose: 8N1 UART receiver that pairs bytes (high byte first) into a 16-bit command word.
// Latency: cmd/cmd_rdy update one clk after the low byte's stop-bit sample (one cycle after byte_vld).
// Backpressure: none; cmd_rdy is a sticky flag cleared by clr_cmd_rdy, and unconsumed commands are overwritten silently.
module cmd_uart_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int BYTE_TO  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int BW = $clog2(BAUD_DIV) + 1;
  localparam int TW = $clog2(BYTE_TO);
  localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(BYTE_TO - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {A_WAIT_HI, A_WAIT_LO} asm_state_t;

  // synchronizer and edge-detect history
  logic rx_meta, rx_s, rx_prev;

  // bit receiver state
  rx_state_t      rx_state, rx_nxt;
  logic [BW-1:0]  baud_cnt, baud_nxt;
  logic [2:0]     bit_cnt, bit_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           byte_vld, byte_vld_nxt;
  logic           frm_err_nxt;
  logic           baud_exp;

  // byte-pair assembler state
  asm_state_t     asm_state, asm_nxt;
  logic [7:0]     hi_byte, hi_nxt;
  logic [TW-1:0]  to_cnt, to_nxt;
  logic [15:0]    cmd_nxt;
  logic           rdy_nxt;

  assign baud_exp = (baud_cnt == BAUD_ONE);

  // Two-flop synchronizer for the asynchronous RX line, plus one flop of history for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receiver registers: state, baud/bit counters, shift register and the one-cycle result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      byte_vld <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_state <= rx_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      byte_vld <= byte_vld_nxt;
      frm_err  <= frm_err_nxt;
    end
  end

  // Receiver next state: half-bit wait to mid start bit, then sample every full bit period.
  always_comb begin
    rx_nxt       = rx_state;
    baud_nxt     = baud_cnt;
    bit_nxt      = bit_cnt;
    shift_nxt    = shift;
    byte_vld_nxt = 1'b0;
    frm_err_nxt  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line held low stays ignored.
        if (rx_prev && !rx_s) begin
          rx_nxt   = R_START;
          baud_nxt = BAUD_HALF;
        end
      end
      R_START: begin
        if (baud_exp) begin
          if (!rx_s) begin
            rx_nxt   = R_DATA;
            baud_nxt = BAUD_FULL;
            bit_nxt  = 3'd0;
          end else begin
            rx_nxt = R_IDLE;  // start bit did not survive to mid-bit: glitch
          end
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
      R_DATA: begin
        if (baud_exp) begin
          shift_nxt = {rx_s, shift[7:1]};  // line is LSB first
          baud_nxt  = BAUD_FULL;
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_nxt = R_STOP;
          end
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
      R_STOP: begin
        if (baud_exp) begin
          byte_vld_nxt = rx_s;
          frm_err_nxt  = !rx_s;
          rx_nxt       = R_IDLE;
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
      default: rx_nxt = R_IDLE;
    endcase
  end

  // Assembler registers: pairing state, stored high byte, inter-byte timer and the command outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state <= A_WAIT_HI;
      hi_byte   <= '0;
      to_cnt    <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      asm_state <= asm_nxt;
      hi_byte   <= hi_nxt;
      to_cnt    <= to_nxt;
      cmd       <= cmd_nxt;
      cmd_rdy   <= rdy_nxt;
    end
  end

  // Assembler next state: pair bytes, drop a lone high byte on timeout or framing error; a set of cmd_rdy beats a clear.
  always_comb begin
    asm_nxt = asm_state;
    hi_nxt  = hi_byte;
    to_nxt  = to_cnt;
    cmd_nxt = cmd;
    rdy_nxt = cmd_rdy & ~clr_cmd_rdy;
    case (asm_state)
      A_WAIT_HI: begin
        if (byte_vld) begin
          hi_nxt  = shift;
          rdy_nxt = 1'b0;
          to_nxt  = '0;
          asm_nxt = A_WAIT_LO;
        end
      end
      A_WAIT_LO: begin
        if (byte_vld) begin
          cmd_nxt = {hi_byte, shift};
          rdy_nxt = 1'b1;
          asm_nxt = A_WAIT_HI;
        end else if (frm_err || (to_cnt == TO_LAST)) begin
          hi_nxt  = '0;
          asm_nxt = A_WAIT_HI;
        end else begin
          // reaching TO_LAST leaves this state, so the count never wraps
          to_nxt = to_cnt + TW'(1);
        end
      end
      default: asm_nxt = A_WAIT_HI;
    endcase
  end

endmodule

// File: tb/tb_cmd_uart_rx.sv
module tb_cmd_uart_rx;

  localparam int BD = 16;
  localparam int BT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  logic hold_clr = 1'b0;
  logic mon_clr  = 1'b0;
  assign clr_cmd_rdy = hold_clr | mon_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state: expected commands, expected framing errors, pending high byte
  logic [15:0] exp_q[$];
  int          exp_frm = 0;
  int          got_frm = 0;
  bit          pend_v = 1'b0;
  logic [7:0]  pend_b = 8'h00;
  int          pend_t = 0;
  int          last_stop_t = 0;

  cmd_uart_rx #(.BAUD_DIV(BD), .BYTE_TO(BT)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Byte-level model: a good byte pairs with a pending high byte if it lands within BYTE_TO
  // cycles of it; otherwise it becomes the new high byte. A bad stop bit drops any pending byte.
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    last_stop_t = cyc;
    if (!ok) begin
      exp_frm++;
      pend_v = 1'b0;
    end else if (pend_v && (cyc - pend_t) < BT) begin
      exp_q.push_back({pend_b, b});
      pend_v = 1'b0;
    end else begin
      pend_v = 1'b1;
      pend_b = b;
      pend_t = cyc;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit ok);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    model_byte(b, ok);
    RX = ok;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch();
    @(negedge clk);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on each new cmd_rdy, checks latency, counts frm_err pulses
  // and clears cmd_rdy after a random delay the way the command processor would.
  initial begin : monitor
    bit          seen;
    bit          frm_prev;
    int          clr_wait;
    logic [15:0] want;
    seen = 1'b0;
    frm_prev = 1'b0;
    clr_wait = -1;
    forever begin
      @(negedge clk);
      mon_clr = 1'b0;
      if (rst) begin
        seen = 1'b0;
        frm_prev = 1'b0;
        clr_wait = -1;
      end else begin
        if (frm_err) begin
          got_frm++;
          if (frm_prev) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frm_err_width: got pulse longer than 1 cycle want 1 cycle");
          end
        end
        frm_prev = frm_err;
        if (cmd_rdy && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_cmd: got %h want no command", cmd);
          end else begin
            want = exp_q.pop_front();
            check("cmd", 32'(cmd), 32'(want));
            n_cmp++;
            if ((cyc - last_stop_t) < BD/2 + 2 || (cyc - last_stop_t) > BD/2 + 6) begin
              n_bad++;
              $display("FAIL cmd_latency: got %0d cycles want %0d..%0d", cyc - last_stop_t, BD/2 + 2, BD/2 + 6);
            end
          end
          clr_wait = $urandom_range(0, 20);
        end else if (!cmd_rdy) begin
          seen = 1'b0;
        end
        if (clr_wait == 0) begin
          mon_clr = 1'b1;
          clr_wait = -1;
        end else if (clr_wait > 0) begin
          clr_wait--;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          w;
    logic [7:0]  b;
    bit          ok;
    @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("rst_frm_err", 32'(frm_err), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(10);

    // back-to-back pair, then the command processor consumes it
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(40);
    check("clr_rdy_low", 32'(cmd_rdy), 32'h0);
    check("cmd_kept_after_clr", 32'(cmd), 32'h0000A53C);

    // short low pulse must not become a byte
    glitch();
    idle(20);
    check("glitch_no_rdy", 32'(cmd_rdy), 32'h0);

    // bad stop bit, then a clean pair must not reuse 8'h12
    send_byte(8'h12, 1'b0);
    idle(5);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    idle(40);

    // lone high byte times out, then a fresh pair; then a lone byte left idle
    send_byte(8'hFF, 1'b1);
    idle(300);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(40);
    send_byte(8'h99, 1'b1);
    idle(300);

    // clear held high while a pair completes: set wins for one cycle
    hold_clr = 1'b1;
    send_byte(8'h77, 1'b1);
    fork
      send_byte(8'h88, 1'b1);
      begin
        w = 0;
        while (!cmd_rdy && w < 400) begin
          @(negedge clk);
          w++;
        end
        check("setwins_rdy_set", 32'(cmd_rdy), 32'h1);
        @(negedge clk);
        check("setwins_rdy_clr", 32'(cmd_rdy), 32'h0);
      end
    join
    hold_clr = 1'b0;
    idle(30);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_byte(b, ok);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(60, 120));
      else idle($urandom_range(0, 8));
      if ($urandom_range(0, 5) == 0) glitch();
    end
    idle(300);

    // reset in the middle of the low byte's data bits
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(40);
    send_byte(8'h33, 1'b1);
    idle(2);
    RX = 1'b0;
    repeat (BD * 4) @(negedge clk);
    rst = 1'b1;
    RX = 1'b1;
    pend_v = 1'b0;
    #1;
    check("async_rst_cmd", 32'(cmd), 32'h0);
    check("async_rst_rdy", 32'(cmd_rdy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    idle(40);
    check("post_rst_cmd", 32'(cmd), 32'h0000BEEF);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("frm_err_count", 32'(got_frm), 32'(exp_frm));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
